// File: rtl/freq_estimator_if.sv
// freq_estimator_if: sample stream in, frequency measurement out.
// The master side feeds samples; the slave side is the estimator.
interface freq_estimator_if #(
    parameter int AMPLITUDE_BITS       = 24,
    parameter int FREQUENCY_TOTAL_BITS = 22
);
    logic                            sample_valid;
    logic [AMPLITUDE_BITS-1:0]       sample;
    logic                            freq_valid;
    logic [FREQUENCY_TOTAL_BITS-1:0] freq;
    logic                            busy;
    logic                            overrun;

    modport master (
        output sample_valid, sample,
        input  freq_valid, freq, busy, overrun
    );

    modport slave (
        input  sample_valid, sample,
        output freq_valid, freq, busy, overrun
    );
endinterface

// File: rtl/freq_estimator.sv
// freq_estimator: measures the period between rising zero crossings of a
// signed sample stream and converts it to a UQ15.7 frequency with a
// restoring shift-subtract divider (fixed 34-clock latency).
// Optional build macro FREQ_ESTIMATOR_AVERAGE_EN: average over four periods.
module freq_estimator #(
    parameter int unsigned SAMPLE_RATE_HZ = 48000,
    parameter int          PERIOD_BITS    = 16,
    parameter logic [23:0] HYSTERESIS     = 24'd4096
) (
    input  logic           clk,
    input  logic           reset_n,
    freq_estimator_if.slave bus
);
    localparam int AMPLITUDE_BITS = 24;
    localparam int FREQ_BITS      = 22;

`ifdef FREQ_ESTIMATOR_AVERAGE_EN
    localparam logic [31:0] DIVIDEND = 32'(SAMPLE_RATE_HZ) << 9;
`else
    localparam logic [31:0] DIVIDEND = 32'(SAMPLE_RATE_HZ) << 7;
`endif

    // Counter value at which one more non-crossing sample means timeout.
    localparam logic [PERIOD_BITS-1:0] COUNT_TIMEOUT = {{(PERIOD_BITS-1){1'b1}}, 1'b0};
    localparam logic signed [AMPLITUDE_BITS-1:0] HYST_POS = $signed(HYSTERESIS);
    localparam logic signed [AMPLITUDE_BITS-1:0] HYST_NEG = -$signed(HYSTERESIS);

    typedef enum logic {WAIT_FIRST, MEASURE} state_t;

    state_t                   state_reg, state_next;
    logic [PERIOD_BITS-1:0]   counter_reg, counter_next;
    logic                     armed_reg, armed_next;
    logic                     load_div, emit_zero, set_overrun;
    logic [31:0]              divisor_load;
    logic [PERIOD_BITS-1:0]   period;
`ifdef FREQ_ESTIMATOR_AVERAGE_EN
    logic [17:0]              acc_reg, acc_next, acc_sum;
    logic [1:0]               acc_cnt_reg, acc_cnt_next;
`endif

    logic                     busy_reg, freq_valid_reg, overrun_reg;
    logic [FREQ_BITS-1:0]     freq_reg, result_reg;
    logic [31:0]              rem_reg, quo_reg, divisor_reg;
    logic [5:0]               step_reg;
    logic [32:0]              rem_shift, rem_diff;
    logic                     quo_bit;
    logic                     div_idle, crossing, below_neg, above_pos;
    logic signed [AMPLITUDE_BITS-1:0] sample_s;

    assign sample_s  = $signed(bus.sample);
    assign below_neg = sample_s < HYST_NEG;
    assign above_pos = sample_s >= HYST_POS;
    assign crossing  = bus.sample_valid && armed_reg && above_pos;
    // The result cycle also counts as busy so a latch never coincides with freq_valid.
    assign div_idle  = !busy_reg && !freq_valid_reg;
    assign period    = counter_reg + 1'b1;

    // Next-state logic: hysteresis arming, period counting, divider launch.
    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        armed_next   = armed_reg;
        load_div     = 1'b0;
        emit_zero    = 1'b0;
        set_overrun  = 1'b0;
        divisor_load = '0;
`ifdef FREQ_ESTIMATOR_AVERAGE_EN
        acc_next     = acc_reg;
        acc_cnt_next = acc_cnt_reg;
        acc_sum      = acc_reg + 18'(period);
`endif
        if (bus.sample_valid) begin
            if (crossing) begin
                armed_next = 1'b0;
            end else if (below_neg) begin
                armed_next = 1'b1;
            end
            case (state_reg)
                WAIT_FIRST: begin
                    if (crossing) begin
                        counter_next = '0;
                        state_next   = MEASURE;
                    end
                end
                MEASURE: begin
                    if (crossing) begin
                        counter_next = '0;
`ifdef FREQ_ESTIMATOR_AVERAGE_EN
                        if (acc_cnt_reg == 2'd3) begin
                            acc_next     = '0;
                            acc_cnt_next = '0;
                            divisor_load = 32'(acc_sum);
                            if (div_idle) load_div = 1'b1;
                            else          set_overrun = 1'b1;
                        end else begin
                            acc_next     = acc_sum;
                            acc_cnt_next = acc_cnt_reg + 1'b1;
                        end
`else
                        divisor_load = 32'(period);
                        if (div_idle) load_div = 1'b1;
                        else          set_overrun = 1'b1;
`endif
                    end else if (counter_reg == COUNT_TIMEOUT) begin
                        counter_next = '0;
                        armed_next   = 1'b0;
                        state_next   = WAIT_FIRST;
                        if (div_idle) emit_zero = 1'b1;
                        else          set_overrun = 1'b1;
                    end else begin
                        counter_next = counter_reg + 1'b1;
                    end
                end
                default: state_next = WAIT_FIRST;
            endcase
        end
`ifdef FREQ_ESTIMATOR_AVERAGE_EN
        // Any partial sum is worthless once lock is lost.
        if (state_next == WAIT_FIRST) begin
            acc_next     = '0;
            acc_cnt_next = '0;
        end
`endif
    end

    // Measurement state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= WAIT_FIRST;
            counter_reg <= '0;
            armed_reg   <= 1'b0;
`ifdef FREQ_ESTIMATOR_AVERAGE_EN
            acc_reg     <= '0;
            acc_cnt_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            armed_reg   <= armed_next;
`ifdef FREQ_ESTIMATOR_AVERAGE_EN
            acc_reg     <= acc_next;
            acc_cnt_reg <= acc_cnt_next;
`endif
        end
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift = {rem_reg, quo_reg[31]};
    assign rem_diff  = rem_shift - {1'b0, divisor_reg};
    assign quo_bit   = rem_shift >= {1'b0, divisor_reg};

    // Divider sequence: 32 quotient steps, one saturation step, one result step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_reg       <= 1'b0;
            freq_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            freq_reg       <= '0;
            result_reg     <= '0;
            rem_reg        <= '0;
            quo_reg        <= '0;
            divisor_reg    <= '0;
            step_reg       <= '0;
        end else begin
            freq_valid_reg <= 1'b0;
            if (set_overrun) overrun_reg <= 1'b1;
            if (load_div) begin
                busy_reg    <= 1'b1;
                rem_reg     <= '0;
                quo_reg     <= DIVIDEND;
                divisor_reg <= divisor_load;
                step_reg    <= '0;
            end else if (busy_reg) begin
                if (step_reg < 6'd32) begin
                    rem_reg  <= quo_bit ? rem_diff[31:0] : rem_shift[31:0];
                    quo_reg  <= {quo_reg[30:0], quo_bit};
                    step_reg <= step_reg + 1'b1;
                end else if (step_reg == 6'd32) begin
                    result_reg <= (|quo_reg[31:FREQ_BITS]) ? '1 : quo_reg[FREQ_BITS-1:0];
                    step_reg   <= step_reg + 1'b1;
                end else begin
                    freq_valid_reg <= 1'b1;
                    freq_reg       <= result_reg;
                    busy_reg       <= 1'b0;
                end
            end else if (emit_zero) begin
                freq_valid_reg <= 1'b1;
                freq_reg       <= '0;
            end
        end
    end

    assign bus.freq_valid = freq_valid_reg;
    assign bus.freq       = freq_reg;
    assign bus.busy       = busy_reg;
    assign bus.overrun    = overrun_reg;
endmodule

// File: tb/tb_freq_estimator.sv
// tb_freq_estimator: directed square-wave vectors with hand-computed
// frequencies, overrun, timeout, small-signal and mid-division reset cases.
`timescale 1ns/1ps
module tb_freq_estimator;
    localparam int AMP = 4194304;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    int     n_checks = 0;
    int     n_errors = 0;
    int     fv_count = 0;
    int     base;
    logic [21:0] fv_last = '0;
    longint cyc = 0;
    longint fv_cyc = 0;
    longint cross_cyc = 0;

    always #5 clk = ~clk;

    freq_estimator_if bus_if ();

    freq_estimator dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Result monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus_if.freq_valid) begin
            fv_count = fv_count + 1;
            fv_last  = bus_if.freq;
            fv_cyc   = cyc;
            $display("freq_valid: freq=%0d cycle=%0d overrun=%0b", bus_if.freq, cyc, bus_if.overrun);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("check %s: %0d ok", tag, got);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus_if.sample_valid = 1'b0;
        bus_if.sample       = '0;
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
    endtask

    task automatic send_sample(input int value, input int gap);
        bus_if.sample       = value[23:0];
        bus_if.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.sample_valid = 1'b0;
        if (gap > 1) idle(gap - 1);
    endtask

    // Negative half first, so each period contains exactly one rising crossing
    // at the first positive sample.
    task automatic square(input int period, input int n_periods, input int gap, input int amp);
        int half_neg;
        half_neg = period / 2;
        for (int p = 0; p < n_periods; p++) begin
            for (int i = 0; i < period; i++) begin
                if (i < half_neg) begin
                    send_sample(-amp, gap);
                end else begin
                    if (i == half_neg) cross_cyc = cyc;
                    send_sample(amp, gap);
                end
            end
        end
    endtask

    initial begin
        bus_if.sample_valid = 1'b0;
        bus_if.sample       = '0;
        #1;
        do_reset();
        check_val("reset_freq_valid", bus_if.freq_valid, 0);
        check_val("reset_freq", bus_if.freq, 0);
        check_val("reset_busy", bus_if.busy, 0);
        check_val("reset_overrun", bus_if.overrun, 0);

        // 480 Hz: period 100, one sample every 4 clocks.
        do_reset();
        base = fv_count;
        square(100, 4, 4, AMP);
        idle(40);
        check_val("p100_count", fv_count - base, 3);
        check_val("p100_freq", fv_last, 61440);
        check_val("p100_overrun", bus_if.overrun, 0);
        check_val("p100_latency", fv_cyc - cross_cyc, 35);

        // 1000 Hz.
        do_reset();
        base = fv_count;
        square(48, 3, 2, AMP);
        idle(40);
        check_val("p48_count", fv_count - base, 2);
        check_val("p48_freq", fv_last, 128000);

        // Period 7 truncates 877714.28.
        do_reset();
        base = fv_count;
        square(7, 3, 8, AMP);
        idle(40);
        check_val("p7_count", fv_count - base, 2);
        check_val("p7_freq", fv_last, 877714);

        // Period 2, slow sample strobe: every period measured.
        do_reset();
        base = fv_count;
        square(2, 4, 20, AMP);
        idle(40);
        check_val("p2_slow_count", fv_count - base, 3);
        check_val("p2_slow_freq", fv_last, 3072000);
        check_val("p2_slow_overrun", bus_if.overrun, 0);

        // Period 2 every clock: latches 36 clocks apart, the rest dropped.
        do_reset();
        base = fv_count;
        square(2, 40, 1, AMP);
        idle(40);
        check_val("p2_fast_count", fv_count - base, 3);
        check_val("p2_fast_freq", fv_last, 3072000);
        check_val("p2_fast_overrun", bus_if.overrun, 1);

        // Reset pulse ten clocks after a latch abandons the division.
        base = fv_count;
        send_sample(-AMP, 1);
        send_sample(AMP, 1);
        idle(9);
        check_val("midrst_busy_before", bus_if.busy, 1);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        check_val("midrst_freq_valid", bus_if.freq_valid, 0);
        check_val("midrst_freq", bus_if.freq, 0);
        check_val("midrst_busy", bus_if.busy, 0);
        check_val("midrst_overrun", bus_if.overrun, 0);
        idle(40);
        check_val("midrst_no_result", fv_count - base, 0);
        send_sample(-AMP, 1);
        send_sample(AMP, 1);
        idle(40);
        check_val("midrst_first_cross", fv_count - base, 0);

        // Timeout: counter is 49 after the last period's positive half.
        do_reset();
        base = fv_count;
        square(100, 2, 1, AMP);
        idle(40);
        check_val("to_lock_count", fv_count - base, 1);
        check_val("to_lock_freq", fv_last, 61440);
        for (int i = 0; i < 65485; i++) send_sample(0, 1);
        idle(2);
        check_val("to_before_edge", fv_count - base, 1);
        send_sample(0, 1);
        idle(2);
        check_val("to_count", fv_count - base, 2);
        check_val("to_freq", fv_last, 0);
        check_val("to_busy", bus_if.busy, 0);
        square(48, 2, 2, AMP);
        idle(40);
        check_val("to_relock_count", fv_count - base, 3);
        check_val("to_relock_freq", fv_last, 128000);

        // Small amplitude never crosses the hysteresis band.
        do_reset();
        base = fv_count;
        square(10, 20, 1, 1000);
        idle(40);
        check_val("small_count", fv_count - base, 0);
        check_val("small_busy", bus_if.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
